// File: rtl/io_initiator_pkg.sv
// Shared types and constants for the register-bus initiator.
package io_initiator_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Port-register responder address map.
  localparam logic [2:0] ADDR_PORTA = 3'd0;
  localparam logic [2:0] ADDR_DDRA  = 3'd1;
  localparam logic [2:0] ADDR_PORTB = 3'd2;
  localparam logic [2:0] ADDR_DDRB  = 3'd3;

  // Width of the read-response wait counter (limit is at most 15).
  localparam int unsigned WAIT_CNT_W = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/io_initiator.sv
// Host-request to register-bus initiator: one bus strobe per request,
// read responses awaited with a bounded timeout, one response per request.
module io_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       bus_enable,
  output logic       bus_we_n,
  output logic [2:0] bus_a,
  output logic [7:0] bus_di,
  input  logic [7:0] bus_do,
  input  logic       bus_oe,
  output logic [7:0] err_count
);
  import io_initiator_pkg::*;

  // Last WAIT cycle is the one whose incremented count reaches TIMEOUT_CYCLES-1.
  localparam logic [WAIT_CNT_W:0] TO_LIMIT = (WAIT_CNT_W + 1)'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_we;
  logic [2:0]            r_addr;
  logic [7:0]            r_wdata;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;
  logic [WAIT_CNT_W:0]   w_cnt_inc;
  logic                  w_timeout;
  logic [7:0]            r_rdata;
  logic [7:0]            w_rdata_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic [7:0]            r_errcnt;
  logic [7:0]            w_errcnt_nxt;
  logic                  w_accept;

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_timeout = (w_cnt_inc >= TO_LIMIT);

  // State, request latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdata  <= w_rdata_nxt;
      r_err    <= w_err_nxt;
      r_errcnt <= w_errcnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  // Next-state and response-data decisions; bus_oe only matters in WAIT.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rdata_nxt  = r_rdata;
    w_err_nxt    = r_err;
    w_errcnt_nxt = r_errcnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_oe) begin
          w_rdata_nxt = bus_do;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc[WAIT_CNT_W-1:0];
          if (w_timeout) begin
            w_rdata_nxt  = '0;
            w_err_nxt    = 1'b1;
            w_errcnt_nxt = sat_inc8(r_errcnt);
            w_state_nxt  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address/data come straight from the request latch, which only changes on
  // accept, so they hold their last value whenever the strobe is low.
  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign bus_enable = (r_state == S_ISSUE);
  assign bus_we_n   = ~(bus_enable & r_we);
  assign bus_a      = r_addr;
  assign bus_di     = r_wdata;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign err_count  = r_errcnt;

endmodule

// File: tb/tb_io_initiator.sv
// Bench for io_initiator against a behavioural port-register responder.
module tb_io_initiator;
  import io_initiator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       bus_enable, bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_di, bus_do;
  logic       bus_oe;
  logic [7:0] err_count;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  int en_cnt = 0;
  logic       last_we_n;
  logic [2:0] last_a;
  logic [7:0] last_di;
  int exp_errs = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  // Responder state: port/DDR registers and external pin inputs.
  logic [7:0] m_porta, m_ddra, m_portb, m_ddrb;
  logic [7:0] pai = 8'h00;
  logic [7:0] pbi = 8'h00;

  io_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_enable(bus_enable), .bus_we_n(bus_we_n), .bus_a(bus_a),
    .bus_di(bus_di), .bus_do(bus_do), .bus_oe(bus_oe),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Cycle index plus bus-strobe monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_enable === 1'b1) begin
      en_cnt    <= en_cnt + 1;
      last_we_n <= bus_we_n;
      last_a    <= bus_a;
      last_di   <= bus_di;
    end
  end

  function automatic logic [7:0] rd_val(input logic [2:0] a);
    case (a)
      ADDR_PORTA: return (m_porta & m_ddra) | (pai & ~m_ddra);
      ADDR_DDRA:  return m_ddra;
      ADDR_PORTB: return (m_portb & m_ddrb) | (pbi & ~m_ddrb);
      ADDR_DDRB:  return m_ddrb;
      default:    return 8'h00;
    endcase
  endfunction

  // Port-register responder: registered read data with OE one cycle after
  // the strobe; addresses 4..7 never answer.
  always @(posedge clk) begin
    if (rst) begin
      m_porta <= 8'h00; m_ddra <= 8'h00; m_portb <= 8'h00; m_ddrb <= 8'h00;
      bus_oe  <= 1'b0;  bus_do <= 8'h00;
    end else begin
      bus_oe <= 1'b0;
      if (bus_enable) begin
        if (!bus_we_n) begin
          case (bus_a)
            ADDR_PORTA: m_porta <= bus_di;
            ADDR_DDRA:  m_ddra  <= bus_di;
            ADDR_PORTB: m_portb <= bus_di;
            ADDR_DDRB:  m_ddrb  <= bus_di;
            default: ;
          endcase
        end else if (bus_a < 3'd4) begin
          bus_oe <= 1'b1;
          bus_do <= rd_val(bus_a);
        end
      end
    end
  end

  task automatic send_req(input logic we, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] er, input logic ee, input int el,
                          output int acc);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
    acc = cyc;
    e.rdata = er; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output logic [7:0] rd, output logic er,
                          output int lat, output bit got);
    got = 1'b0; lat = -1; rd = 'x; er = 1'bx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      lat = cyc - acc;
      rd  = rsp_rdata;
      er  = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin miss++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    vec++; if (rsp_rdata !== 8'h00) begin miss++; $display("FAIL rst_rsp_rdata got %h want 00", rsp_rdata); end
    vec++; if (rsp_err !== 1'b0) begin miss++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    vec++; if (bus_enable !== 1'b0) begin miss++; $display("FAIL rst_bus_enable got %b want 0", bus_enable); end
    vec++; if (bus_we_n !== 1'b1) begin miss++; $display("FAIL rst_bus_we_n got %b want 1", bus_we_n); end
    vec++; if (bus_a !== 3'd0) begin miss++; $display("FAIL rst_bus_a got %0d want 0", bus_a); end
    vec++; if (bus_di !== 8'h00) begin miss++; $display("FAIL rst_bus_di got %h want 00", bus_di); end
    vec++; if (err_count !== 8'h00) begin miss++; $display("FAIL rst_err_count got %h want 00", err_count); end
  endtask

  task automatic test_write_read;
    int acc, lat, en0;
    logic [7:0] rd;
    logic er;
    bit got;
    exp_t e;
    // write DDRA = 0xFF
    en0 = en_cnt;
    send_req(1'b1, ADDR_DDRA, 8'hFF, 8'h00, 1'b0, 2, acc);
    wait_rsp(acc, rd, er, lat, got);
    e = sb.pop_front();
    vec++; if (!got || lat != e.lat) begin miss++; $display("FAIL wr_latency got %0d want %0d", lat, e.lat); end
    vec++; if (rd !== e.rdata) begin miss++; $display("FAIL wr_rdata got %h want %h", rd, e.rdata); end
    vec++; if (er !== e.err) begin miss++; $display("FAIL wr_err got %b want %b", er, e.err); end
    vec++; if (en_cnt - en0 != 1) begin miss++; $display("FAIL wr_strobe_cycles got %0d want 1", en_cnt - en0); end
    vec++; if ({last_we_n, last_a, last_di} !== {1'b0, ADDR_DDRA, 8'hFF}) begin
      miss++; $display("FAIL wr_bus_fields got we_n=%b a=%0d di=%h want 0/1/ff", last_we_n, last_a, last_di);
    end
    // read DDRA back
    en0 = en_cnt;
    send_req(1'b0, ADDR_DDRA, 8'h00, 8'hFF, 1'b0, 3, acc);
    wait_rsp(acc, rd, er, lat, got);
    e = sb.pop_front();
    vec++; if (!got || lat != e.lat) begin miss++; $display("FAIL rd_latency got %0d want %0d", lat, e.lat); end
    vec++; if (rd !== e.rdata) begin miss++; $display("FAIL rd_rdata got %h want %h", rd, e.rdata); end
    vec++; if (er !== e.err) begin miss++; $display("FAIL rd_err got %b want %b", er, e.err); end
    vec++; if (en_cnt - en0 != 1) begin miss++; $display("FAIL rd_strobe_cycles got %0d want 1", en_cnt - en0); end
    vec++; if ({last_we_n, last_a} !== {1'b1, ADDR_DDRA}) begin
      miss++; $display("FAIL rd_bus_fields got we_n=%b a=%0d want 1/1", last_we_n, last_a);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] er;
    logic       ee;
    int         el;
  } step_t;

  task automatic test_port_mix;
    step_t tbl[8];
    int acc, lat;
    logic [7:0] rd;
    logic er;
    bit got;
    exp_t e;
    pai = 8'h3C;
    pbi = 8'hC3;
    tbl = '{
      '{1'b1, ADDR_DDRA,  8'h0F, 8'h00, 1'b0, 2},
      '{1'b1, ADDR_PORTA, 8'hA5, 8'h00, 1'b0, 2},
      '{1'b0, ADDR_PORTA, 8'h00, 8'h35, 1'b0, 3},
      '{1'b1, ADDR_DDRB,  8'hF0, 8'h00, 1'b0, 2},
      '{1'b1, ADDR_PORTB, 8'h5A, 8'h00, 1'b0, 2},
      '{1'b0, ADDR_PORTB, 8'h00, 8'h53, 1'b0, 3},
      '{1'b1, 3'd6,       8'h77, 8'h00, 1'b0, 2},
      '{1'b0, ADDR_DDRB,  8'h00, 8'hF0, 1'b0, 3}
    };
    for (int i = 0; i < 8; i++) begin
      send_req(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee, tbl[i].el, acc);
      wait_rsp(acc, rd, er, lat, got);
      e = sb.pop_front();
      vec++; if (!got || lat != e.lat) begin miss++; $display("FAIL mix%0d_latency got %0d want %0d", i, lat, e.lat); end
      vec++; if (rd !== e.rdata) begin miss++; $display("FAIL mix%0d_rdata got %h want %h", i, rd, e.rdata); end
      vec++; if (er !== e.err) begin miss++; $display("FAIL mix%0d_err got %b want %b", i, er, e.err); end
    end
  endtask

  task automatic test_timeout;
    int acc, lat, en0;
    logic [7:0] rd;
    logic er;
    bit got;
    exp_t e;
    en0 = en_cnt;
    send_req(1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 5, acc);
    wait_rsp(acc, rd, er, lat, got);
    e = sb.pop_front();
    exp_errs = exp_errs + 1;
    vec++; if (!got || lat != e.lat) begin miss++; $display("FAIL to_latency got %0d want %0d", lat, e.lat); end
    vec++; if (rd !== e.rdata) begin miss++; $display("FAIL to_rdata got %h want %h", rd, e.rdata); end
    vec++; if (er !== e.err) begin miss++; $display("FAIL to_err got %b want %b", er, e.err); end
    vec++; if (err_count !== 8'(exp_errs)) begin miss++; $display("FAIL to_err_count got %h want %h", err_count, 8'(exp_errs)); end
    vec++; if (en_cnt - en0 != 1) begin miss++; $display("FAIL to_strobe_cycles got %0d want 1", en_cnt - en0); end
  endtask

  task automatic test_backpressure;
    int acc, acc2, lat, en0;
    logic [7:0] rd;
    logic er;
    bit got;
    exp_t e;
    send_req(1'b0, ADDR_DDRA, 8'h00, 8'h0F, 1'b0, 3, acc);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (rsp_valid === 1'b1);
    end
    e = sb.pop_front();
    vec++; if (!got || cyc - acc != e.lat) begin miss++; $display("FAIL bp_latency got %0d want %0d", cyc - acc, e.lat); end
    // A competing request waits while the response is held off.
    req_valid = 1'b1; req_we = 1'b1; req_addr = ADDR_PORTB; req_wdata = 8'h11;
    en0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec++; if (rsp_valid !== 1'b1) begin miss++; $display("FAIL bp_hold%0d_valid got %b want 1", i, rsp_valid); end
      vec++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miss++; $display("FAIL bp_hold%0d_data got %h/%b want %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      vec++; if (req_ready !== 1'b0) begin miss++; $display("FAIL bp_hold%0d_req_ready got %b want 0", i, req_ready); end
    end
    vec++; if (en_cnt != en0) begin miss++; $display("FAIL bp_no_strobe got %0d want 0", en_cnt - en0); end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    vec++; if (req_ready !== 1'b1 || bus_enable !== 1'b0) begin
      miss++; $display("FAIL bp_no_same_cycle_accept got ready=%b en=%b want 1/0", req_ready, bus_enable);
    end
    acc2 = cyc;
    e.rdata = 8'h00; e.err = 1'b0; e.lat = 2;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(acc2, rd, er, lat, got);
    e = sb.pop_front();
    vec++; if (!got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
      miss++; $display("FAIL bp_followup got lat=%0d %h/%b want lat=%0d %h/%b", lat, rd, er, e.lat, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_midflight;
    int acc, seen;
    send_req(1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 5, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_front());
    exp_errs = 0;
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL mr_rsp_valid got %b want 0", rsp_valid); end
    vec++; if (bus_enable !== 1'b0) begin miss++; $display("FAIL mr_bus_enable got %b want 0", bus_enable); end
    vec++; if (req_ready !== 1'b1) begin miss++; $display("FAIL mr_req_ready got %b want 1", req_ready); end
    vec++; if (bus_a !== 3'd0) begin miss++; $display("FAIL mr_bus_a got %0d want 0", bus_a); end
    vec++; if (err_count !== 8'(exp_errs)) begin miss++; $display("FAIL mr_err_count got %h want 00", err_count); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || bus_enable !== 1'b0) seen++;
    end
    vec++; if (seen != 0) begin miss++; $display("FAIL mr_quiet got %0d active cycles want 0", seen); end
  endtask

  task automatic test_err_saturate;
    int acc, lat;
    logic [7:0] rd;
    logic er;
    bit got;
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      send_req(1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 5, acc);
      wait_rsp(acc, rd, er, lat, got);
      e = sb.pop_front();
      exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      vec++; if (!got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
        miss++; $display("FAIL sat%0d_rsp got lat=%0d %h/%b want lat=%0d %h/%b", i, lat, rd, er, e.lat, e.rdata, e.err);
      end
      vec++; if (err_count !== 8'(exp_errs)) begin
        miss++; $display("FAIL sat%0d_err_count got %h want %h", i, err_count, 8'(exp_errs));
      end
    end
    vec++; if (err_count !== 8'hFF) begin miss++; $display("FAIL sat_final got %h want ff", err_count); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_port_mix();
    test_timeout();
    test_backpressure();
    test_reset_midflight();
    test_err_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/io_initiator.md
IO_INITIATOR -- requirements
Module: io_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4, SHALL set the read-response wait limit in cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 req_we  input  1  1 = register write, 0 = register read.
REQ-007 req_addr  input  3  register select.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-011 rsp_rdata  output  8  read data; 0x00 for writes and timeouts.
REQ-012 rsp_err  output  1  1 = read timed out.
REQ-013 bus_enable  output  1  register-bus select strobe to responder.
REQ-014 bus_we_n  output  1  0 = write, 1 = read.
REQ-015 bus_a  output  3  register address.
REQ-016 bus_di  output  8  write data to responder.
REQ-017 bus_do  input  8  read data from responder.
REQ-018 bus_oe  input  1  responder read-data valid.
REQ-019 err_count  output  8  saturating count of timed-out reads.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; only IDLE asserts req_ready.
REQ-021 IDLE: on req_valid & req_ready, SHALL latch req_we/req_addr/req_wdata and go to ISSUE.
REQ-022 ISSUE: SHALL drive bus_enable=1 for exactly one cycle with bus_we_n=~we, bus_a=addr, bus_di=wdata from latched values.
REQ-023 Outside ISSUE: bus_enable=0, bus_we_n=1, bus_a and bus_di hold last value.
REQ-024 ISSUE with write: next state RESP, rsp_rdata=0x00, rsp_err=0 (writes are unacknowledged by the responder, including addresses 4..7).
REQ-025 ISSUE with read: next state WAIT, wait counter cleared to 0.
REQ-026 WAIT: bus_oe=1 SHALL capture bus_do into rsp_rdata, rsp_err=0, go to RESP; nominal responder returns OE in the first WAIT cycle (read latency: request accept to rsp_valid = 3 cycles).
REQ-027 WAIT without bus_oe: counter increments; when counter reaches TIMEOUT_CYCLES-1 with bus_oe=0, SHALL go to RESP with rsp_rdata=0x00, rsp_err=1, err_count incremented.
REQ-028 err_count SHALL saturate at 0xFF.
REQ-029 bus_oe in IDLE, ISSUE, or RESP SHALL be ignored.
REQ-030 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then IDLE; a new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-031 Minimum write transaction: accept -> ISSUE -> RESP, rsp_valid in the 2nd cycle after accept.

Reset
REQ-032 rst SHALL force IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, bus_enable=0, bus_we_n=1, bus_a=0, bus_di=0x00, err_count=0, counter=0.
REQ-033 rst mid-transaction SHALL abort it: the in-flight bus strobe and pending response are dropped, with no response emitted.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and register address constants (PORTA=0, DDRA=1, PORTB=2, DDRB=3).
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 The bench SHALL connect io_initiator to the existing port-register responder and cover:
- Write addr 1 data 0xFF, then read addr 1 -> rsp_rdata=0xFF, rsp_err=0, bus_enable high exactly 1 cycle per access.
- DDRA=0x0F, PORTA write 0xA5, PAI=0x3C, read addr 0 -> rsp_rdata=0x35.
- Read addr 5, TIMEOUT_CYCLES=4 -> rsp_err=1, rsp_rdata=0x00, rsp_valid 5 cycles after accept, err_count=1.
- rsp_ready held 0 for 10 cycles -> rsp_valid and data stable, req_ready=0, no bus_enable.
- rst pulsed during WAIT -> rsp_valid stays 0, bus_enable=0, req_ready=1 next cycle.
- 256 timed-out reads -> err_count=0xFF, no wrap.
